// File: rtl/condicionador_pkg.sv
// condicionador_pkg
//    Shared types and constants for the push-button conditioning stage.
//    - estado_cond_t : FSM state type with fixed 3-bit encodings
//                      (also exported on the db_estado debug port).
//    - N_BOTOES      : number of push-button lines.
//    - DB_ESTADO_W   : width of the debug state port.
//    - conta_bits    : population count of a button vector.
package condicionador_pkg;

   localparam int unsigned N_BOTOES    = 4;
   localparam int unsigned DB_ESTADO_W = 3;

   typedef enum logic [DB_ESTADO_W-1:0] {
      OCIOSO      = 3'b000,
      FILTRANDO   = 3'b001,
      PRESSIONADO = 3'b010,
      SOLTANDO    = 3'b011
   } estado_cond_t;

   function automatic int unsigned conta_bits(input logic [N_BOTOES-1:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < N_BOTOES; i++) begin
         n += int'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/condicionador_botoes_sincronizador_2ff.sv
// sincronizador_2ff
//    Two-flop synchroniser for asynchronous inputs, parameterised width.
//    Ports:
//       clock  in           system clock, rising edge
//       reset  in           synchronous, active-high; clears both stages
//       d      in  LARGURA  asynchronous input bus
//       q      out LARGURA  second-stage (synchronised) value
module sincronizador_2ff #(
   parameter int unsigned LARGURA = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [LARGURA-1:0] d,
   output logic [LARGURA-1:0] q
);

   logic [LARGURA-1:0] estagio1_q, estagio1_d;
   logic [LARGURA-1:0] estagio2_q, estagio2_d;

   always_comb begin
      estagio1_d = d;
      estagio2_d = estagio1_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estagio1_q <= '0;
         estagio2_q <= '0;
      end else begin
         estagio1_q <= estagio1_d;
         estagio2_q <= estagio2_d;
      end
   end

   assign q = estagio2_q;

endmodule

// File: rtl/condicionador_botoes.sv
// condicionador_botoes
//    Synchronises and debounces four raw push buttons and emits one
//    registered one-hot play code with a single-cycle strobe per accepted
//    press. A press must be followed by a debounced release before the
//    next one can be accepted.
//    Optional feature macro: CONDICIONADOR_INVALIDA_EN (adds the
//    jogada_invalida strobe for multi-button presses).
//    Parameters:
//       DEBOUNCE_CICLOS  stable synchronised samples to accept press/release (1..255)
//    Ports:
//       clock            in  1  system clock, rising edge
//       reset            in  1  synchronous, active-high
//       botoes           in  4  raw asynchronous button lines, active-high
//       habilita         in  1  presses are accepted only while high
//       jogada           out 4  last accepted one-hot code
//       jogada_feita     out 1  one-cycle strobe when jogada updates
//       jogada_invalida  out 1  one-cycle strobe on multi-button press (macro only)
//       db_estado        out 3  current FSM encoding
module condicionador_botoes
   import condicionador_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CICLOS = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N_BOTOES-1:0]    botoes,
   input  logic                   habilita,
   output logic [N_BOTOES-1:0]    jogada,
   output logic                   jogada_feita,
`ifdef CONDICIONADOR_INVALIDA_EN
   output logic                   jogada_invalida,
`endif
   output logic [DB_ESTADO_W-1:0] db_estado
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS + 1);
   localparam logic [CW-1:0] D_C   = CW'(DEBOUNCE_CICLOS);
   localparam logic [CW-1:0] UM_C  = CW'(1);

   logic [N_BOTOES-1:0] s;

   estado_cond_t        estado_q, estado_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [N_BOTOES-1:0] cand_q, cand_d;
   logic [N_BOTOES-1:0] jogada_q, jogada_d;
   logic                feita_q, feita_d;
`ifdef CONDICIONADOR_INVALIDA_EN
   logic                invalida_q, invalida_d;
`endif

   logic [CW-1:0]       cnt_inc;
   logic                s_nao_zero;
   logic                s_multi;
   logic                s_one_hot;

   sincronizador_2ff #(
      .LARGURA (N_BOTOES)
   ) u_sinc (
      .clock (clock),
      .reset (reset),
      .d     (botoes),
      .q     (s)
   );

   // Saturating increment; saturation also lets D=1 leave SOLTANDO on the
   // first zero sample after entry.
   always_comb begin
      cnt_inc    = (cnt_q >= D_C) ? D_C : cnt_q + UM_C;
      s_nao_zero = (s != '0);
      s_multi    = ((s & (s - N_BOTOES'(1))) != '0);
      s_one_hot  = s_nao_zero && !s_multi;
   end

   always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q;
      cand_d   = cand_q;
      jogada_d = jogada_q;
      feita_d  = 1'b0;
`ifdef CONDICIONADOR_INVALIDA_EN
      invalida_d = 1'b0;
`endif
      case (estado_q)
         OCIOSO: begin
            if (s_nao_zero) begin
               if (s_one_hot && habilita) begin
                  cand_d = s;
                  cnt_d  = UM_C;
                  // With a single-sample filter the first sample is the accept.
                  if (D_C == UM_C) begin
                     estado_d = PRESSIONADO;
                     jogada_d = s;
                     feita_d  = 1'b1;
                  end else begin
                     estado_d = FILTRANDO;
                  end
               end else begin
                  estado_d = PRESSIONADO;
`ifdef CONDICIONADOR_INVALIDA_EN
                  invalida_d = habilita && s_multi;
`endif
               end
            end
         end
         FILTRANDO: begin
            if (!habilita || (s != cand_q)) begin
               estado_d = OCIOSO;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == D_C) begin
                  estado_d = PRESSIONADO;
                  jogada_d = cand_q;
                  feita_d  = 1'b1;
               end
            end
         end
         PRESSIONADO: begin
            if (!s_nao_zero) begin
               estado_d = SOLTANDO;
               cnt_d    = UM_C;
            end
         end
         SOLTANDO: begin
            if (s_nao_zero) begin
               estado_d = PRESSIONADO;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == D_C) begin
                  estado_d = OCIOSO;
               end
            end
         end
         default: begin
            estado_d = OCIOSO;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q <= OCIOSO;
         cnt_q    <= '0;
         cand_q   <= '0;
         jogada_q <= '0;
         feita_q  <= 1'b0;
`ifdef CONDICIONADOR_INVALIDA_EN
         invalida_q <= 1'b0;
`endif
      end else begin
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
         cand_q   <= cand_d;
         jogada_q <= jogada_d;
         feita_q  <= feita_d;
`ifdef CONDICIONADOR_INVALIDA_EN
         invalida_q <= invalida_d;
`endif
      end
   end

   assign jogada       = jogada_q;
   assign jogada_feita = feita_q;
`ifdef CONDICIONADOR_INVALIDA_EN
   assign jogada_invalida = invalida_q;
`endif
   assign db_estado    = estado_q;

endmodule
